demo_scene_sequencer: RTL and testbench
=======================================

# demo_scene_sequencer

Frame-level controller for the VGA demo datapath. It consumes the beam position from `hvsync_generator` and produces a one-cycle start-of-vblank tick and a free-running frame counter for scroll offsets. A scene state machine steps through `NUM_SCENES` effects with fade-in, show, fade-out and switch phases, and emits the controls that gate the PCG noise overlay. It replaces all logic clocked from `vsync`: everything runs on `clk`.

## Interface

Parameters:
- `NUM_SCENES`, default 4: number of scenes, range 2..4. `scene_id` wraps at `NUM_SCENES-1`.
- `SCENE_FRAMES`, default 240: frames spent in SHOW, range 1..256.
- `V_VISIBLE`, default 480: first non-visible line; the tick fires there.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high reset.
- `hpos` in 10: beam column from `hvsync_generator`.
- `vpos` in 10: beam row from `hvsync_generator`.
- `display_on` in 1: visible-area flag.
- `hold` in 1: level input. Freezes the SHOW timer.
- `skip` in 1: single-cycle pulse. Requests early exit from the current scene.
- `frame_tick` out 1: one-cycle pulse at the start of vblank.
- `frame_count` out 10: frame counter, wraps.
- `scene_id` out 2: current scene.
- `fade_level` out 4: brightness, 0 = black and 15 = full.
- `phase` out 2: state encoding. FADE_IN=0, SHOW=1, FADE_OUT=2, SWITCH=3.
- `noise_en` out 1: enables the PCG overlay gate.
- `prng_reseed` out 1: reloads the PCG state to a fixed seed.
- `prng_step` out 1: advances the PCG state.

## Operation

Tick generation:
- `frame_tick` is registered. It is 1 in the cycle after the inputs show `hpos==0 && vpos==V_VISIBLE`; otherwise it is 0.

Frame counter:
- `frame_count` increments on each edge where `frame_tick==1`.
- It wraps 1023 -> 0.
- `hold` does not affect it.

Scene state machine. All transitions below happen only on edges where `frame_tick==1`, except SWITCH.
- FADE_IN: `fade_level` increments by 1 per tick. On a tick with `fade_level==15`, go to SHOW with `timer` = 0.
- SHOW: `timer` (8 bits) increments per tick unless `hold==1`.
  - On a tick with `timer==SCENE_FRAMES-1` and `hold==0`, go to FADE_OUT.
  - On any tick with `skip_pend==1`, go to FADE_OUT. This applies even when `hold==1`.
  - Leaving SHOW clears `skip_pend`.
- FADE_OUT: `fade_level` decrements by 1 per tick. On a tick with `fade_level==0`, go to SWITCH.
- SWITCH: lasts exactly one cycle and needs no tick.
  - `scene_id` becomes `scene_id+1`, or 0 if it was `NUM_SCENES-1`.
  - `fade_level` = 0 and `timer` = 0.
  - Next state is FADE_IN.

Skip handling:
- A `skip` pulse sets `skip_pend` in FADE_IN and SHOW.
- In FADE_OUT and SWITCH, a pulse is ignored and clears `skip_pend`.
- A skip that arrives during FADE_IN takes effect on the first SHOW tick after SHOW is entered, not on the entry tick itself.

Outputs:
- `noise_en` = 1 when `phase` is FADE_IN or FADE_OUT. Registered, so it follows `phase` by 0 cycles.
- `prng_reseed` = `frame_tick`. Every frame's noise pattern therefore restarts from the same seed.
- `prng_step` = `display_on` registered by one cycle, aligned with the pixel pipeline.
- When `prng_reseed` and `prng_step` are both 1, reseed has priority.

Reset values. `reset` is sampled on `clk` and takes effect at any point, including mid-frame and mid-fade:
- `frame_tick`, `frame_count`, `scene_id`, `fade_level`, `timer`, `skip_pend` = 0.
- `phase` = FADE_IN.
- `noise_en` = 1.
- `prng_reseed`, `prng_step` = 0.

## Timing

- `frame_tick` latency is 1 cycle from the qualifying `hpos`/`vpos`. It repeats once per frame: 420000 clocks at 800x525.
- State, counter and fade updates land on the edge of the tick cycle. They are visible the cycle after `frame_tick` is high.
- Full cycle length per scene, without skip or hold: 16 ticks FADE_IN + `SCENE_FRAMES` ticks SHOW + 16 ticks FADE_OUT + 1 clk SWITCH.
- `skip` and a tick in the same cycle:
  - In SHOW, the skip takes effect on the next tick, not on this one. `skip_pend` is sampled before update.
  - In FADE_IN, it sets `skip_pend` as normal.
- No combinational path from inputs to outputs.

## Test plan

- **Reset mid-fade.** Reset asserted at `vpos`=100 during FADE_OUT with `fade_level`=7 -> next cycle all outputs are at reset values. The first `frame_tick` occurs 1 clk after `vpos`=480 and `hpos`=0.
- **Nominal sequence.** `SCENE_FRAMES`=3, free run -> `fade_level` 0..15 over 16 ticks, then SHOW for 3 ticks, then 15..0 over 16 ticks, then `phase`=3 for 1 clk. `scene_id` goes 0 -> 1 and `noise_en` is 0 only in SHOW. `scene_id` wraps 3 -> 0 after four scenes.
- **Hold.** `hold`=1 throughout SHOW for 50 ticks -> `timer` is constant and `phase` stays SHOW. `frame_count` advances by 50.
- **Skip.**
  - Skip pulse 5 clks after the second SHOW tick -> FADE_OUT on the third tick.
  - Skip during FADE_IN -> FADE_OUT on the first tick after SHOW entry.
  - Skip during FADE_OUT -> no effect.
- **Counter wrap and reseed.** `frame_count` 1023 -> 0 on a tick, and `prng_reseed` is high in exactly that cycle. `prng_step` equals `display_on` delayed by 1 clk, and is suppressed by reseed when both are high.
- **Skip with hold.** `skip` and `hold` both set in SHOW -> FADE_OUT at the next tick.

Source files
------------

// File: rtl/demo_scene_sequencer.sv
// Frame-level scene controller: start-of-vblank tick, frame counter, and a
// fade-in/show/fade-out/switch scene FSM that gates the PCG noise overlay.
module demo_scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 240,
  parameter int V_VISIBLE    = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hold,
  input  logic       skip,
  output logic       frame_tick,
  output logic [9:0] frame_count,
  output logic [1:0] scene_id,
  output logic [3:0] fade_level,
  output logic [1:0] phase,
  output logic       noise_en,
  output logic       prng_reseed,
  output logic       prng_step
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    SHOW     = 2'd1,
    FADE_OUT = 2'd2,
    SWITCH   = 2'd3
  } phase_t;

  localparam logic [9:0] TICK_ROW   = 10'(V_VISIBLE);
  localparam logic [7:0] SHOW_LAST  = 8'(SCENE_FRAMES - 1);
  localparam logic [1:0] SCENE_LAST = 2'(NUM_SCENES - 1);

  phase_t     state;
  logic [7:0] timer;
  logic       skip_pend;
  logic       step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
      scene_id    <= '0;
      fade_level  <= '0;
      timer       <= '0;
      skip_pend   <= 1'b0;
      step_q      <= 1'b0;
      state       <= FADE_IN;
    end else begin
      frame_tick <= (hpos == 10'd0) && (vpos == TICK_ROW);
      step_q     <= display_on;
      if (frame_tick) frame_count <= frame_count + 10'd1;

      case (state)
        FADE_IN: begin
          if (skip) skip_pend <= 1'b1;
          if (frame_tick) begin
            if (fade_level == 4'd15) begin
              state <= SHOW;
              timer <= '0;
            end else begin
              fade_level <= fade_level + 4'd1;
            end
          end
        end
        SHOW: begin
          // skip_pend is the pre-edge value, so a skip landing on a tick waits for the next one
          if (frame_tick && (skip_pend || (!hold && timer == SHOW_LAST))) begin
            state     <= FADE_OUT;
            skip_pend <= 1'b0;
          end else begin
            if (skip) skip_pend <= 1'b1;
            if (frame_tick && !hold) timer <= timer + 8'd1;
          end
        end
        FADE_OUT: begin
          skip_pend <= 1'b0;
          if (frame_tick) begin
            if (fade_level == 4'd0) state <= SWITCH;
            else fade_level <= fade_level - 4'd1;
          end
        end
        default: begin
          skip_pend  <= 1'b0;
          scene_id   <= (scene_id == SCENE_LAST) ? 2'd0 : scene_id + 2'd1;
          fade_level <= '0;
          timer      <= '0;
          state      <= FADE_IN;
        end
      endcase
    end
  end

  // Pure decodes of registers: no input reaches an output combinationally.
  assign phase       = state;
  assign noise_en    = (state == FADE_IN) || (state == FADE_OUT);
  assign prng_reseed = frame_tick;
  assign prng_step   = step_q & ~frame_tick;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer; beam position is driven directly
// so a frame is a 2-cycle tick instead of a full raster.
module tb_demo_scene_sequencer;

  logic       clk = 1'b0;
  logic       reset, display_on, hold, skip;
  logic [9:0] hpos, vpos;
  logic       frame_tick, noise_en, prng_reseed, prng_step;
  logic [9:0] frame_count;
  logic [1:0] scene_id, phase;
  logic [3:0] fade_level;

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  demo_scene_sequencer #(.NUM_SCENES(4), .SCENE_FRAMES(3), .V_VISIBLE(480)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hold(hold), .skip(skip), .frame_tick(frame_tick), .frame_count(frame_count),
    .scene_id(scene_id), .fade_level(fade_level), .phase(phase), .noise_en(noise_en),
    .prng_reseed(prng_reseed), .prng_step(prng_step)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick();
    hpos = 10'd0; vpos = 10'd480; cyc();
    hpos = 10'd5; vpos = 10'd0;   cyc();
    exp_fc = (exp_fc + 1) % 1024;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_skip();
    skip = 1'b1; cyc(); skip = 1'b0; cyc();
  endtask

  task automatic test_reset();
    logic [22:0] got, want;
    reset = 1'b1; cyc();
    got  = {frame_tick, frame_count, scene_id, fade_level, phase, noise_en, prng_reseed, prng_step};
    want = {1'b0, 10'd0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (got !== want) begin $display("FAIL reset_values got=%h want=%h", got, want); n_err++; end
    reset = 1'b0; exp_fc = 0; cyc(3);
    n_cmp++;
    if (frame_tick !== 1'b0 || frame_count !== 10'd0) begin
      $display("FAIL idle_no_tick tick=%b fc=%0d want 0/0", frame_tick, frame_count); n_err++;
    end
  endtask

  task automatic test_nominal();
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (fade_level !== 4'(k < 16 ? k : 15) || phase !== 2'(k < 16 ? 0 : 1) || noise_en !== (k < 16)) begin
        $display("FAIL fade_in k=%0d fade=%0d phase=%0d noise=%b", k, fade_level, phase, noise_en); n_err++;
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (phase !== 2'(k < 3 ? 1 : 2) || noise_en !== (k == 3) || fade_level !== 4'd15) begin
        $display("FAIL show k=%0d phase=%0d noise=%b fade=%0d", k, phase, noise_en, fade_level); n_err++;
      end
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (fade_level !== 4'(k < 16 ? 15 - k : 0) || phase !== 2'(k < 16 ? 2 : 3) ||
          noise_en !== (k < 16) || scene_id !== 2'd0) begin
        $display("FAIL fade_out k=%0d fade=%0d phase=%0d noise=%b scene=%0d", k, fade_level, phase, noise_en, scene_id);
        n_err++;
      end
    end
    cyc();
    n_cmp++;
    if (phase !== 2'd0 || scene_id !== 2'd1 || fade_level !== 4'd0 || noise_en !== 1'b1 || frame_count !== 10'd35) begin
      $display("FAIL after_switch phase=%0d scene=%0d fade=%0d noise=%b fc=%0d want 0/1/0/1/35",
               phase, scene_id, fade_level, noise_en, frame_count); n_err++;
    end
    for (int s = 2; s <= 4; s++) begin
      ticks(35); cyc();
      n_cmp++;
      if (scene_id !== 2'(s % 4) || phase !== 2'd0) begin
        $display("FAIL scene_wrap scene=%0d want %0d phase=%0d", scene_id, s % 4, phase); n_err++;
      end
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    ticks(16);
    hold = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (phase !== 2'd1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin $display("FAIL hold_phase left SHOW on %0d ticks want 0", bad); n_err++; end
    n_cmp++;
    if (frame_count !== 10'(140 + 16 + 50)) begin
      $display("FAIL hold_frame_count got=%0d want=%0d", frame_count, 140 + 16 + 50); n_err++;
    end
    hold = 1'b0;
    ticks(2);
    n_cmp++;
    if (phase !== 2'd1) begin $display("FAIL hold_timer_frozen phase=%0d want 1", phase); n_err++; end
    tick();
    n_cmp++;
    if (phase !== 2'd2) begin $display("FAIL hold_release_exit phase=%0d want 2", phase); n_err++; end
    ticks(16); cyc();
  endtask

  task automatic test_skip();
    // skip between first and second SHOW ticks exits early
    ticks(16); tick(); cyc(5); pulse_skip(); cyc(3); tick();
    n_cmp++;
    if (phase !== 2'd2) begin $display("FAIL skip_show phase=%0d want 2", phase); n_err++; end
    ticks(16); cyc();
    // skip coincident with a SHOW tick waits for the next tick
    ticks(16);
    hpos = 10'd0; vpos = 10'd480; cyc();
    skip = 1'b1; hpos = 10'd5; vpos = 10'd0; cyc(); skip = 1'b0;
    exp_fc = (exp_fc + 1) % 1024;
    n_cmp++;
    if (phase !== 2'd1) begin $display("FAIL skip_same_tick phase=%0d want 1", phase); n_err++; end
    tick();
    n_cmp++;
    if (phase !== 2'd2) begin $display("FAIL skip_next_tick phase=%0d want 2", phase); n_err++; end
    ticks(16); cyc();
    // skip during FADE_IN survives the SHOW entry tick
    cyc(3); pulse_skip(); ticks(16);
    n_cmp++;
    if (phase !== 2'd1) begin $display("FAIL skip_fade_in_entry phase=%0d want 1", phase); n_err++; end
    tick();
    n_cmp++;
    if (phase !== 2'd2) begin $display("FAIL skip_fade_in_exit phase=%0d want 2", phase); n_err++; end
    // skip during FADE_OUT is dropped
    ticks(4); pulse_skip(); tick();
    n_cmp++;
    if (phase !== 2'd2 || fade_level !== 4'd10) begin
      $display("FAIL skip_fade_out phase=%0d fade=%0d want 2/10", phase, fade_level); n_err++;
    end
    ticks(10);
    n_cmp++;
    if (phase !== 2'd2 || fade_level !== 4'd0) begin
      $display("FAIL fade_out_floor phase=%0d fade=%0d want 2/0", phase, fade_level); n_err++;
    end
    tick();
    n_cmp++;
    if (phase !== 2'd3) begin $display("FAIL switch_phase phase=%0d want 3", phase); n_err++; end
    cyc(); ticks(18);
    n_cmp++;
    if (phase !== 2'd1 || scene_id !== 2'd0) begin
      $display("FAIL skip_cleared phase=%0d scene=%0d want 1/0", phase, scene_id); n_err++;
    end
    tick();
    n_cmp++;
    if (phase !== 2'd2) begin $display("FAIL skip_cleared_exit phase=%0d want 2", phase); n_err++; end
    ticks(16); cyc();
  endtask

  task automatic test_skip_hold();
    ticks(16); hold = 1'b1; ticks(2);
    n_cmp++;
    if (phase !== 2'd1) begin $display("FAIL hold_before_skip phase=%0d want 1", phase); n_err++; end
    pulse_skip(); tick();
    n_cmp++;
    if (phase !== 2'd2 || noise_en !== 1'b1) begin
      $display("FAIL skip_with_hold phase=%0d noise=%b want 2/1", phase, noise_en); n_err++;
    end
    hold = 1'b0; ticks(16); cyc();
  endtask

  task automatic test_wrap_reseed();
    display_on = 1'b1; cyc();
    n_cmp++;
    if (prng_step !== 1'b1) begin $display("FAIL step_follow got=%b want 1", prng_step); n_err++; end
    display_on = 1'b0; cyc();
    n_cmp++;
    if (prng_step !== 1'b0) begin $display("FAIL step_drop got=%b want 0", prng_step); n_err++; end
    while (exp_fc != 1023) tick();
    n_cmp++;
    if (frame_count !== 10'd1023 || prng_reseed !== 1'b0) begin
      $display("FAIL pre_wrap fc=%0d reseed=%b want 1023/0", frame_count, prng_reseed); n_err++;
    end
    display_on = 1'b1; hpos = 10'd0; vpos = 10'd480; cyc();
    n_cmp++;
    if (frame_tick !== 1'b1 || prng_reseed !== 1'b1 || prng_step !== 1'b0 || frame_count !== 10'd1023) begin
      $display("FAIL wrap_tick tick=%b reseed=%b step=%b fc=%0d want 1/1/0/1023",
               frame_tick, prng_reseed, prng_step, frame_count); n_err++;
    end
    hpos = 10'd5; vpos = 10'd0; cyc(); exp_fc = 0;
    n_cmp++;
    if (frame_count !== 10'd0 || prng_reseed !== 1'b0 || prng_step !== 1'b1) begin
      $display("FAIL wrap_after fc=%0d reseed=%b step=%b want 0/0/1", frame_count, prng_reseed, prng_step); n_err++;
    end
    display_on = 1'b0; cyc();
  endtask

  task automatic test_reset_mid_fade();
    logic [22:0] got, want;
    reset = 1'b1; cyc(); reset = 1'b0; exp_fc = 0;
    ticks(16 + 3 + 8);
    n_cmp++;
    if (phase !== 2'd2 || fade_level !== 4'd7) begin
      $display("FAIL mid_fade_setup phase=%0d fade=%0d want 2/7", phase, fade_level); n_err++;
    end
    hpos = 10'd5; vpos = 10'd100; reset = 1'b1; cyc(); reset = 1'b0;
    got  = {frame_tick, frame_count, scene_id, fade_level, phase, noise_en, prng_reseed, prng_step};
    want = {1'b0, 10'd0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (got !== want) begin $display("FAIL mid_fade_reset got=%h want=%h", got, want); n_err++; end
    hpos = 10'd1; vpos = 10'd480; cyc();
    n_cmp++;
    if (frame_tick !== 1'b0) begin $display("FAIL tick_wrong_col got=%b want 0", frame_tick); n_err++; end
    hpos = 10'd0; cyc();
    n_cmp++;
    if (frame_tick !== 1'b1) begin $display("FAIL first_tick got=%b want 1", frame_tick); n_err++; end
    hpos = 10'd2; cyc();
    n_cmp++;
    if (frame_tick !== 1'b0 || frame_count !== 10'd1 || fade_level !== 4'd1) begin
      $display("FAIL first_tick_after tick=%b fc=%0d fade=%0d want 0/1/1", frame_tick, frame_count, fade_level); n_err++;
    end
  endtask

  initial begin
    reset = 1'b1; display_on = 1'b0; hold = 1'b0; skip = 1'b0;
    hpos = 10'd5; vpos = 10'd0;
    cyc(2);
    test_reset();
    test_nominal();
    test_hold();
    test_skip();
    test_skip_hold();
    test_wrap_reseed();
    test_reset_mid_fade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
